// File: rtl/axi4_w_burst_buffer.sv
// AXI4 W-channel beat buffer with optional burst store-and-forward (STORE_FWD=1).
// Optional statistics ports (fill_level, burst_cnt) are built when AXI4_W_BUF_STATS_EN is defined.
module axi4_w_burst_buffer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 4,
  parameter int BUFFER_DEPTH   = 8,
  parameter int STORE_FWD      = 0
) (
  input  logic                                 axi4_aclk,
  input  logic                                 axi4_arst,
  input  logic [AXI_DATA_WIDTH-1:0]            s_axi4_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]          s_axi4_wstrb,
  input  logic                                 s_axi4_wlast,
  input  logic [AXI_USER_WIDTH-1:0]            s_axi4_wuser,
  input  logic                                 s_axi4_wvalid,
  output logic                                 s_axi4_wready,
  output logic [AXI_DATA_WIDTH-1:0]            m_axi4_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]          m_axi4_wstrb,
  output logic                                 m_axi4_wlast,
  output logic [AXI_USER_WIDTH-1:0]            m_axi4_wuser,
  output logic                                 m_axi4_wvalid,
  input  logic                                 m_axi4_wready,
`ifdef AXI4_W_BUF_STATS_EN
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]    fill_level,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]    burst_cnt,
`endif
  output logic                                 o_fsm_state
);

  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int EW = AXI_USER_WIDTH + SW + AXI_DATA_WIDTH + 1;

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  // Handshake: a beat transfers on a side in any cycle where valid && ready on that side.
  // Neither ready nor valid depends combinationally on the opposite side of the buffer.
  logic [EW-1:0] r_mem [BUFFER_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_bursts;
  logic [0:0]    r_state;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_mvalid;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_out;
  logic          w_burst_inc;
  logic          w_burst_dec;

  assign w_full      = (r_count == CW'(BUFFER_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_push      = s_axi4_wvalid && s_axi4_wready;
  assign w_pop       = w_mvalid && m_axi4_wready;
  assign w_burst_inc = w_push && s_axi4_wlast;
  assign w_burst_dec = w_pop && w_head[0];

  // In HOLD only complete bursts are released; FWD drains an oversized burst.
  always_comb begin
    w_mvalid = !w_empty;
    if (STORE_FWD != 0 && r_state == ST_HOLD) begin
      w_mvalid = !w_empty && (r_bursts != '0);
    end
  end

  assign s_axi4_wready = !axi4_arst && !w_full;
  assign m_axi4_wvalid = w_mvalid;
  assign w_out         = w_mvalid ? w_head : '0;
  assign {m_axi4_wuser, m_axi4_wstrb, m_axi4_wdata, m_axi4_wlast} = w_out;
  assign o_fsm_state   = r_state;

  always_ff @(posedge axi4_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axi4_wuser, s_axi4_wstrb, s_axi4_wdata, s_axi4_wlast};
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bursts <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_burst_inc && !w_burst_dec) begin
        r_bursts <= r_bursts + CW'(1);
      end else if (w_burst_dec && !w_burst_inc) begin
        r_bursts <= r_bursts - CW'(1);
      end
    end
  end

  // Escape to FWD when the buffer is full of a burst that has no wlast yet.
  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      r_state <= ST_HOLD;
    end else if (STORE_FWD != 0) begin
      case (r_state)
        ST_HOLD: if (w_full && r_bursts == '0) r_state <= ST_FWD;
        ST_FWD:  if (w_burst_dec) r_state <= ST_HOLD;
        default: r_state <= ST_HOLD;
      endcase
    end
  end

`ifdef AXI4_W_BUF_STATS_EN
  assign fill_level = r_count;
  assign burst_cnt  = r_bursts;
`endif

endmodule

// File: tb/tb_axi4_w_burst_buffer.sv
// Randomized bench for axi4_w_burst_buffer: three instances (cut-through/8, store-fwd/8, store-fwd/4)
// checked every cycle against queue-based models of buffer contents and burst release rules.
module tb_axi4_w_burst_buffer;

  localparam int N  = 3;
  localparam int EW = 41;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst_req;
  logic        s_wvalid [N];
  logic        s_wready [N];
  logic        s_wlast  [N];
  logic [31:0] s_wdata  [N];
  logic [3:0]  s_wstrb  [N];
  logic [3:0]  s_wuser  [N];
  logic        m_wvalid [N];
  logic        m_wready [N];
  logic        m_wlast  [N];
  logic [31:0] m_wdata  [N];
  logic [3:0]  m_wstrb  [N];
  logic [3:0]  m_wuser  [N];
  logic        fsm      [N];
`ifdef AXI4_W_BUF_STATS_EN
  logic [3:0]  fill_lvl [N];
  logic [3:0]  bcnt     [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DEP = (g == 2) ? 4 : 8;
    localparam int SF  = (g == 0) ? 0 : 1;
`ifdef AXI4_W_BUF_STATS_EN
    logic [$clog2(DEP+1)-1:0] w_fl;
    logic [$clog2(DEP+1)-1:0] w_bc;
    assign fill_lvl[g] = 4'(w_fl);
    assign bcnt[g]     = 4'(w_bc);
`endif
    axi4_w_burst_buffer #(
      .AXI_DATA_WIDTH(32), .AXI_USER_WIDTH(4), .BUFFER_DEPTH(DEP), .STORE_FWD(SF)
    ) u_dut (
      .axi4_aclk     (clk),
      .axi4_arst     (rst),
      .s_axi4_wdata  (s_wdata[g]),
      .s_axi4_wstrb  (s_wstrb[g]),
      .s_axi4_wlast  (s_wlast[g]),
      .s_axi4_wuser  (s_wuser[g]),
      .s_axi4_wvalid (s_wvalid[g]),
      .s_axi4_wready (s_wready[g]),
      .m_axi4_wdata  (m_wdata[g]),
      .m_axi4_wstrb  (m_wstrb[g]),
      .m_axi4_wlast  (m_wlast[g]),
      .m_axi4_wuser  (m_wuser[g]),
      .m_axi4_wvalid (m_wvalid[g]),
      .m_axi4_wready (m_wready[g]),
`ifdef AXI4_W_BUF_STATS_EN
      .fill_level    (w_fl),
      .burst_cnt     (w_bc),
`endif
      .o_fsm_state   (fsm[g])
    );
  end

  // Scoreboard: one expected queue per instance, entries packed {user, strb, data, last}.
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  bit            esc  [N];
  int            beat [N];
  int            blen [N];
  int            vpct;
  int            rpct;
  int            total = 0;
  int            bad   = 0;

  function automatic int dep_of(int d);
    return (d == 2) ? 4 : 8;
  endfunction

  function automatic int sf_of(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int q_size(int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [EW-1:0] q_at(int d, int i);
    case (d)
      0:       return exp_q0[i];
      1:       return exp_q1[i];
      default: return exp_q2[i];
    endcase
  endfunction

  function automatic bit q_has_last(int d);
    for (int i = 0; i < q_size(d); i++) begin
      logic [EW-1:0] e;
      e = q_at(d, i);
      if (e[0]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int q_lasts(int d);
    int n;
    n = 0;
    for (int i = 0; i < q_size(d); i++) begin
      logic [EW-1:0] e;
      e = q_at(d, i);
      if (e[0]) n++;
    end
    return n;
  endfunction

  task automatic q_push(input int d, input logic [EW-1:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int d, output logic [EW-1:0] v);
    case (d)
      0:       v = exp_q0.pop_front();
      1:       v = exp_q1.pop_front();
      default: v = exp_q2.pop_front();
    endcase
  endtask

  task automatic q_clear(input int d);
    case (d)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  function automatic int new_len(int d);
    return (sf_of(d) != 0) ? int'($urandom_range(1, dep_of(d) + 2)) : int'($urandom_range(1, 4));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs at negedge, drive new inputs, advance the model at posedge.
  task automatic step();
    bit            ev  [N];
    bit            hl  [N];
    bit            psh [N];
    bit            pp  [N];
    int            sz  [N];
    logic [EW-1:0] ent [N];
    logic [EW-1:0] head;
    logic [EW-1:0] popped;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      sz[d] = q_size(d);
      hl[d] = q_has_last(d);
      ev[d] = (sz[d] > 0) && (sf_of(d) == 0 || hl[d] || esc[d]);
      head  = ev[d] ? q_at(d, 0) : '0;
      chk($sformatf("wready[%0d]", d), 64'(s_wready[d]), 64'(!rst && sz[d] < dep_of(d)));
      chk($sformatf("wvalid[%0d]", d), 64'(m_wvalid[d]), 64'(ev[d]));
      chk($sformatf("payload[%0d]", d), 64'({m_wuser[d], m_wstrb[d], m_wdata[d], m_wlast[d]}), 64'(head));
      chk($sformatf("fsm[%0d]", d), 64'(fsm[d]), 64'(esc[d]));
`ifdef AXI4_W_BUF_STATS_EN
      chk($sformatf("fill_level[%0d]", d), 64'(fill_lvl[d]), 64'(sz[d]));
      chk($sformatf("burst_cnt[%0d]", d), 64'(bcnt[d]), 64'(q_lasts(d)));
`endif
    end
    rst = rst_req;
    for (int d = 0; d < N; d++) begin
      s_wvalid[d] = !rst && ($urandom_range(0, 99) < vpct);
      s_wdata[d]  = $urandom;
      s_wstrb[d]  = 4'($urandom);
      s_wuser[d]  = 4'($urandom);
      s_wlast[d]  = (beat[d] == blen[d] - 1);
      m_wready[d] = ($urandom_range(0, 99) < rpct);
      ent[d]      = {s_wuser[d], s_wstrb[d], s_wdata[d], s_wlast[d]};
      psh[d]      = s_wvalid[d] && !rst && (sz[d] < dep_of(d));
      pp[d]       = ev[d] && m_wready[d];
    end
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      if (rst) begin
        q_clear(d);
        esc[d]  = 1'b0;
        beat[d] = 0;
        blen[d] = new_len(d);
      end else begin
        popped = '0;
        if (pp[d]) q_pop(d, popped);
        if (pp[d] && popped[0]) begin
          esc[d] = 1'b0;
        end else if (sf_of(d) != 0 && !esc[d] && sz[d] == dep_of(d) && !hl[d]) begin
          esc[d] = 1'b1;
        end
        if (psh[d]) begin
          q_push(d, ent[d]);
          if (ent[d][0]) begin
            beat[d] = 0;
            blen[d] = new_len(d);
          end else begin
            beat[d]++;
          end
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    rst_req = 1'b1;
    vpct    = 0;
    rpct    = 0;
    for (int d = 0; d < N; d++) begin
      s_wvalid[d] = 1'b0;
      s_wdata[d]  = '0;
      s_wstrb[d]  = '0;
      s_wuser[d]  = '0;
      s_wlast[d]  = 1'b0;
      m_wready[d] = 1'b0;
      esc[d]      = 1'b0;
      beat[d]     = 0;
      blen[d]     = new_len(d);
    end
    repeat (2) @(posedge clk);
    step();
    rst_req = 1'b0;
    repeat (2) step();

    // Fill with the sink stalled, then drain.
    vpct = 100; rpct = 0;
    repeat (12) step();
    rpct = 100; vpct = 0;
    repeat (14) step();
    vpct = 100; rpct = 100;
    repeat (20) step();

    // Reset with beats held.
    vpct = 100; rpct = 0;
    repeat (6) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (3) step();

    for (int p = 0; p < 10; p++) begin
      vpct = $urandom_range(20, 100);
      rpct = $urandom_range(10, 100);
      repeat (200) step();
      if (p == 5) begin
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
      end
    end
    rpct = 100; vpct = 0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
